// File: rtl/lstm_init_pkg.sv
// rtl/lstm_init_pkg.sv - shared type codes, segment lengths, FSM states and helpers for the LSTM init receiver
package lstm_init_pkg;

  localparam logic [2:0] TYPE_W    = 3'd0;
  localparam logic [2:0] TYPE_B    = 3'd1;
  localparam logic [2:0] TYPE_CTX  = 3'd2;
  localparam logic [2:0] TYPE_IDLE = 3'd7;

  localparam int SEG_W_BYTES   = 512;
  localparam int SEG_B_BYTES   = 32;
  localparam int SEG_CTX_BYTES = 16;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LOAD_W   = 2'd1;
  localparam logic [1:0] ST_LOAD_B   = 2'd2;
  localparam logic [1:0] ST_LOAD_CTX = 2'd3;

  localparam int ERR_OVF   = 0;
  localparam int ERR_SHORT = 1;

  typedef enum logic [1:0] {
    SEG_W   = 2'd0,
    SEG_B   = 2'd1,
    SEG_CTX = 2'd2,
    SEG_NONE = 2'd3
  } seg_e;

  function automatic logic is_load_type(input logic [2:0] t);
    return (t == TYPE_W) || (t == TYPE_B) || (t == TYPE_CTX);
  endfunction

  function automatic logic is_rsv_type(input logic [2:0] t);
    return !is_load_type(t) && (t != TYPE_IDLE);
  endfunction

  function automatic logic [1:0] type_to_state(input logic [2:0] t);
    case (t)
      TYPE_W:   return ST_LOAD_W;
      TYPE_B:   return ST_LOAD_B;
      TYPE_CTX: return ST_LOAD_CTX;
      default:  return ST_IDLE;
    endcase
  endfunction

  function automatic logic [2:0] state_to_type(input logic [1:0] s);
    case (s)
      ST_LOAD_W:   return TYPE_W;
      ST_LOAD_B:   return TYPE_B;
      ST_LOAD_CTX: return TYPE_CTX;
      default:     return TYPE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/lstm_init_seg_counter.sv
// rtl/lstm_init_seg_counter.sv - per-burst byte counter with segment length compare
module lstm_init_seg_counter #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          clear,
  input  logic          inc,
  input  logic [CW-1:0] len,
  output logic [CW-1:0] index,
  output logic          last,
  output logic          overflow
);

  logic [CW-1:0] cnt;

  // A start counts the byte captured at index 0; the count saturates once the segment is full
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(1);
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !overflow) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign index    = cnt;
  // last: the byte arriving now completes the segment
  assign last     = (cnt == len - 1'b1);
  // overflow: segment already full, any further byte is surplus
  assign overflow = (cnt >= len);

endmodule

// File: rtl/lstm_init_receiver.sv
// rtl/lstm_init_receiver.sv - LSTM parameter-init stream receiver; optional LSTM_INIT_CHECKSUM_EN adds oChecksum/oChk_type
module lstm_init_receiver
  import lstm_init_pkg::*;
#(
  parameter int W_BYTES   = SEG_W_BYTES,
  parameter int B_BYTES   = SEG_B_BYTES,
  parameter int CTX_BYTES = SEG_CTX_BYTES,
  parameter int DW        = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       iInit_valid,
  input  logic [DW-1:0]              iInit_data,
  input  logic [2:0]                 iInit_type,
  output logic                       oW_we,
  output logic [$clog2(W_BYTES)-1:0] oW_addr,
  output logic [DW-1:0]              oW_data,
  output logic [DW*B_BYTES-1:0]      oBias,
  output logic [DW*CTX_BYTES/2-1:0]  oCt_init,
  output logic [DW*CTX_BYTES/2-1:0]  oHt_init,
  output logic                       oW_done,
  output logic                       oB_done,
  output logic                       oCtx_done,
  output logic                       oParam_ready,
  output logic [1:0]                 oErr
`ifdef LSTM_INIT_CHECKSUM_EN
  ,
  output logic [7:0]                 oChecksum,
  output logic [2:0]                 oChk_type
`endif
);

  localparam int CW   = $clog2(W_BYTES + 1);
  localparam int AW   = $clog2(W_BYTES);
  localparam int HALF = CTX_BYTES / 2;

  logic [1:0]    state;
  logic [2:0]    cur_type;
  logic          in_load;
  logic          same_seg;
  logic          seg_start;
  logic          seg_term;
  logic          accept;
  logic          ovf_err;
  logic          rsv_err;
  logic          short_err;
  logic          wr_en;
  logic [2:0]    wr_type;
  logic [CW-1:0] wr_idx;
  logic          done_set;
  logic [CW-1:0] seg_len;
  logic [CW-1:0] cnt_idx;
  logic          cnt_last;
  logic          cnt_full;

  // Length of the segment currently being loaded
  always_comb begin
    case (state)
      ST_LOAD_B:   seg_len = CW'(B_BYTES);
      ST_LOAD_CTX: seg_len = CW'(CTX_BYTES);
      default:     seg_len = CW'(W_BYTES);
    endcase
  end

  // Classify the incoming byte: continue, start a new segment, terminate, or flag an error
  always_comb begin
    cur_type  = state_to_type(state);
    in_load   = (state != ST_IDLE);
    same_seg  = in_load && iInit_valid && (iInit_type == cur_type);
    // A type change with valid held high both ends the old burst and starts the new one
    seg_start = iInit_valid && is_load_type(iInit_type) && !same_seg;
    seg_term  = in_load && !same_seg;
    accept    = same_seg && !cnt_full;
    ovf_err   = same_seg && cnt_full;
    rsv_err   = iInit_valid && is_rsv_type(iInit_type);
    short_err = seg_term && !cnt_full;
    wr_en     = seg_start || accept;
    wr_type   = seg_start ? iInit_type : cur_type;
    wr_idx    = seg_start ? '0 : cnt_idx;
    done_set  = accept && cnt_last;
  end

  lstm_init_seg_counter #(
    .CW (CW)
  ) u_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .start    (seg_start),
    .clear    (seg_term),
    .inc      (accept),
    .len      (seg_len),
    .index    (cnt_idx),
    .last     (cnt_last),
    .overflow (cnt_full)
  );

  // FSM: enter the matching load state on a segment start, fall back to idle when the burst ends
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else if (seg_start) begin
      state <= type_to_state(iInit_type);
    end else if (seg_term) begin
      state <= ST_IDLE;
    end
  end

  // Weight RAM port is registered one cycle behind the sampled byte
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oW_we   <= 1'b0;
      oW_addr <= '0;
      oW_data <= '0;
    end else begin
      oW_we <= wr_en && (wr_type == TYPE_W);
      if (wr_en && (wr_type == TYPE_W)) begin
        oW_addr <= wr_idx[AW-1:0];
        oW_data <= iInit_data;
      end
    end
  end

  // Bias bytes land in the holding register slice selected by their index
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oBias <= '0;
    end else begin
      for (int k = 0; k < B_BYTES; k++) begin
        if (wr_en && (wr_type == TYPE_B) && (wr_idx == CW'(k))) begin
          oBias[k*DW +: DW] <= iInit_data;
        end
      end
    end
  end

  // Context bytes: lower half of the index range is Ct, upper half is Ht
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oCt_init <= '0;
      oHt_init <= '0;
    end else begin
      for (int k = 0; k < CTX_BYTES; k++) begin
        if (wr_en && (wr_type == TYPE_CTX) && (wr_idx == CW'(k))) begin
          if (k < HALF) begin
            oCt_init[k*DW +: DW] <= iInit_data;
          end else begin
            oHt_init[(k-HALF)*DW +: DW] <= iInit_data;
          end
        end
      end
    end
  end

  // Done flags: cleared by the first byte of a reload, set by the byte that completes the segment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oW_done   <= 1'b0;
      oB_done   <= 1'b0;
      oCtx_done <= 1'b0;
    end else begin
      oW_done   <= (oW_done && !(seg_start && (iInit_type == TYPE_W))) ||
                   (done_set && (cur_type == TYPE_W));
      oB_done   <= (oB_done && !(seg_start && (iInit_type == TYPE_B))) ||
                   (done_set && (cur_type == TYPE_B));
      oCtx_done <= (oCtx_done && !(seg_start && (iInit_type == TYPE_CTX))) ||
                   (done_set && (cur_type == TYPE_CTX));
    end
  end

  // Sticky protocol error bits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oErr <= 2'b00;
    end else begin
      oErr[ERR_OVF]   <= oErr[ERR_OVF] || ovf_err || rsv_err;
      oErr[ERR_SHORT] <= oErr[ERR_SHORT] || short_err;
    end
  end

  assign oParam_ready = oW_done && oB_done && oCtx_done;

`ifdef LSTM_INIT_CHECKSUM_EN
  // Running modulo-256 sum of the accepted bytes of the most recently started segment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oChecksum <= 8'h00;
      oChk_type <= 3'd0;
    end else if (seg_start) begin
      oChecksum <= 8'(iInit_data);
      oChk_type <= iInit_type;
    end else if (accept) begin
      oChecksum <= oChecksum + 8'(iInit_data);
    end
  end
`endif

endmodule

// File: tb/tb_lstm_init_receiver.sv
// tb/tb_lstm_init_receiver.sv - self-checking bench for lstm_init_receiver with a behavioural segment model
module tb_lstm_init_receiver;

  logic         clk;
  logic         resetn;
  logic         iInit_valid;
  logic [7:0]   iInit_data;
  logic [2:0]   iInit_type;
  logic         oW_we;
  logic [8:0]   oW_addr;
  logic [7:0]   oW_data;
  logic [255:0] oBias;
  logic [63:0]  oCt_init;
  logic [63:0]  oHt_init;
  logic         oW_done;
  logic         oB_done;
  logic         oCtx_done;
  logic         oParam_ready;
  logic [1:0]   oErr;
`ifdef LSTM_INIT_CHECKSUM_EN
  logic [7:0]   oChecksum;
  logic [2:0]   oChk_type;
`endif

  lstm_init_receiver dut (
    .clk          (clk),
    .resetn       (resetn),
    .iInit_valid  (iInit_valid),
    .iInit_data   (iInit_data),
    .iInit_type   (iInit_type),
    .oW_we        (oW_we),
    .oW_addr      (oW_addr),
    .oW_data      (oW_data),
    .oBias        (oBias),
    .oCt_init     (oCt_init),
    .oHt_init     (oHt_init),
    .oW_done      (oW_done),
    .oB_done      (oB_done),
    .oCtx_done    (oCtx_done),
    .oParam_ready (oParam_ready),
    .oErr         (oErr)
`ifdef LSTM_INIT_CHECKSUM_EN
    ,
    .oChecksum    (oChecksum),
    .oChk_type    (oChk_type)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   exp_w [512];
  logic [7:0]   obs_w [512];
  int           exp_wr_cnt = 0;
  int           obs_wr_cnt = 0;
  logic [255:0] exp_bias;
  logic [63:0]  exp_ct;
  logic [63:0]  exp_ht;
  logic [2:0]   exp_done;
  logic [1:0]   exp_err;
  logic [7:0]   exp_chk;
  logic [2:0]   exp_chk_t;
  logic [7:0]   pay [$];

  // Weight RAM seen by the bench: every write strobe lands in a bench-side memory
  always @(negedge clk) begin
    if (oW_we === 1'b1) begin
      obs_w[oW_addr] = oW_data;
      obs_wr_cnt++;
    end
  end

  function automatic int seglen_of(input logic [2:0] t);
    case (t)
      3'd0:    return 512;
      3'd1:    return 32;
      3'd2:    return 16;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_bias  = '0;
    exp_ct    = '0;
    exp_ht    = '0;
    exp_done  = '0;
    exp_err   = '0;
    exp_chk   = '0;
    exp_chk_t = '0;
  endtask

  task automatic check_all(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 512; i++) if (obs_w[i] !== exp_w[i]) bad++;
    chk({tag, "/w_ram_bad"}, bad, 0);
    chk({tag, "/w_writes"}, obs_wr_cnt, exp_wr_cnt);
    chk({tag, "/bias"}, oBias, exp_bias);
    chk({tag, "/ct"}, oCt_init, exp_ct);
    chk({tag, "/ht"}, oHt_init, exp_ht);
    chk({tag, "/w_done"}, oW_done, exp_done[0]);
    chk({tag, "/b_done"}, oB_done, exp_done[1]);
    chk({tag, "/ctx_done"}, oCtx_done, exp_done[2]);
    chk({tag, "/ready"}, oParam_ready, &exp_done);
    chk({tag, "/err"}, oErr, exp_err);
`ifdef LSTM_INIT_CHECKSUM_EN
    chk({tag, "/chk"}, oChecksum, exp_chk);
    chk({tag, "/chk_type"}, oChk_type, exp_chk_t);
`endif
  endtask

  // Drive the queued payload as one burst, then apply the segment rules to the model
  task automatic send(input logic [2:0] t, input bit gap);
    int n;
    int seglen;
    int k;
    n = pay.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      iInit_valid = 1'b1;
      iInit_type  = t;
      iInit_data  = pay[i];
    end
    seglen = seglen_of(t);
    if (seglen > 0 && n > 0) begin
      exp_chk = 8'h00;
      for (int i = 0; i < n && i < seglen; i++) begin
        exp_chk = exp_chk + pay[i];
        case (t)
          3'd0: begin exp_w[i] = pay[i]; exp_wr_cnt++; end
          3'd1: exp_bias[8*i +: 8] = pay[i];
          default: begin
            if (i < 8) exp_ct[8*i +: 8] = pay[i];
            else begin k = i - 8; exp_ht[8*k +: 8] = pay[i]; end
          end
        endcase
      end
      exp_chk_t = t;
      exp_done[t[1:0]] = (n >= seglen);
      if (n < seglen) exp_err[1] = 1'b1;
      if (n > seglen) exp_err[0] = 1'b1;
    end else if (t != 3'd7 && n > 0) begin
      exp_err[0] = 1'b1;
    end
    if (gap) begin
      @(negedge clk);
      iInit_valid = 1'b0;
      iInit_type  = 3'd7;
      iInit_data  = 8'h00;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic fill_rand(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  task automatic fill_ramp(input int n, input logic [7:0] base);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(base + 8'(i));
  endtask

  // Asynchronous reset pulse away from the sampling edge, with an all-zero output check
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    resetn      = 1'b0;
    iInit_valid = 1'b0;
    iInit_type  = 3'd7;
    iInit_data  = 8'h00;
    #1;
    model_clear();
    chk({tag, "/rst_we"}, oW_we, 1'b0);
    chk({tag, "/rst_addr"}, oW_addr, 9'd0);
    chk({tag, "/rst_data"}, oW_data, 8'd0);
    check_all({tag, "/rst"});
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [2:0] tl [12];
    int r;
    bit gap;

    resetn      = 1'b0;
    iInit_valid = 1'b0;
    iInit_type  = 3'd7;
    iInit_data  = 8'h00;
    for (int i = 0; i < 512; i++) begin exp_w[i] = 8'h00; obs_w[i] = 8'h00; end
    model_clear();
    repeat (3) @(negedge clk);
    do_reset("init");

    // Full load sequence
    fill_ramp(512, 8'h00);
    send(3'd0, 1'b1);
    fill_ramp(32, 8'h10);
    send(3'd1, 1'b1);
    fill_ramp(16, 8'hA0);
    send(3'd2, 1'b1);
    check_all("full");
    chk("full/bias_lo", oBias[7:0], 8'h10);
    chk("full/bias_hi", oBias[255:248], 8'h2F);
    chk("full/ct_const", oCt_init, 64'hA7A6A5A4A3A2A1A0);
    chk("full/ht_const", oHt_init, 64'hAFAEADACABAAA9A8);
    chk("full/ready_const", oParam_ready, 1'b1);
    chk("full/err_const", oErr, 2'b00);

    // Short bias burst
    do_reset("short");
    fill_rand(20);
    send(3'd1, 1'b1);
    check_all("short");
    chk("short/b_done", oB_done, 1'b0);
    chk("short/err1", oErr[1], 1'b1);
    chk("short/bias_tail_zero", oBias[255:160], 96'h0);

    // Context overflow
    fill_rand(18);
    send(3'd2, 1'b1);
    check_all("ovf");
    chk("ovf/ctx_done", oCtx_done, 1'b1);
    chk("ovf/err0", oErr[0], 1'b1);

    // Type switch without a valid gap
    do_reset("switch");
    fill_rand(32);
    send(3'd1, 1'b0);
    fill_rand(16);
    send(3'd2, 1'b1);
    check_all("switch");
    chk("switch/err", oErr, 2'b00);

    // Randomised bursts around the segment boundaries
    do_reset("rnd");
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) tl[i] = 3'd0;
      else if (r <= 3) tl[i] = 3'd1;
      else if (r <= 6) tl[i] = 3'd2;
      else if (r == 7) tl[i] = 3'(3 + $urandom_range(0, 3));
      else tl[i] = 3'd7;
    end
    for (int i = 0; i < 12; i++) begin
      if (seglen_of(tl[i]) > 0) fill_rand(seglen_of(tl[i]) - 3 + $urandom_range(0, 6));
      else fill_rand($urandom_range(1, 4));
      gap = (i == 11) || (tl[i+1 > 11 ? 11 : i+1] == tl[i]) || ($urandom_range(0, 1) == 1);
      send(tl[i], gap);
      if (gap) check_all("rnd");
    end

    // Reset in the middle of a weight load
    do_reset("mid_pre");
    fill_rand(100);
    send(3'd0, 1'b0);
    do_reset("mid");
    fill_rand(512);
    send(3'd0, 1'b1);
    check_all("mid_after");
    chk("mid_after/w_done", oW_done, 1'b1);

`ifdef LSTM_INIT_CHECKSUM_EN
    fill_ramp(16, 8'h01);
    send(3'd2, 1'b1);
    chk("cksum/value", oChecksum, 8'h88);
    chk("cksum/type", oChk_type, 3'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
